// File: rtl/motion_bound_scheduler_if.sv
// Bundles the frame-control, configuration and renderer-read signals of
// motion_bound_scheduler. The master side drives ticks, bounds and
// writes. The slave side is the scheduler.
interface motion_bound_scheduler_if #(
  parameter int IDX_W   = 3,
  parameter int COORD_W = 16
);
  logic                      frame_tick;
  logic                      mode;
  logic signed [COORD_W-1:0] x_min;
  logic signed [COORD_W-1:0] x_max;
  logic signed [COORD_W-1:0] y_min;
  logic signed [COORD_W-1:0] y_max;
  logic                      cfg_we;
  logic [IDX_W-1:0]          cfg_idx;
  logic signed [COORD_W-1:0] cfg_x;
  logic signed [COORD_W-1:0] cfg_y;
  logic signed [COORD_W-1:0] cfg_vx;
  logic signed [COORD_W-1:0] cfg_vy;
  logic [IDX_W-1:0]          rd_idx;
  logic signed [COORD_W-1:0] rd_x;
  logic signed [COORD_W-1:0] rd_y;
  logic                      busy;
  logic                      done;
  logic                      hit;
  logic                      overrun;
  logic                      cfg_drop;

  modport master (
    output frame_tick, mode, x_min, x_max, y_min, y_max,
    output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_vy, rd_idx,
    input  rd_x, rd_y, busy, done, hit, overrun, cfg_drop
  );

  modport slave (
    input  frame_tick, mode, x_min, x_max, y_min, y_max,
    input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_vy, rd_idx,
    output rd_x, rd_y, busy, done, hit, overrun, cfg_drop
  );
endinterface

// File: rtl/motion_bound_scheduler.sv
// Per-frame object sequencer. Each accepted frame_tick walks the object
// table once. For each object it adds the velocity to the position, then
// snaps any axis that left the shadowed rectangle. A snapped axis either
// bounces (velocity negated) or stops (velocity zeroed).
module motion_bound_scheduler #(
  parameter int NUM_OBJ = 8,
  parameter int IDX_W   = 3,
  parameter int COORD_W = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  motion_bound_scheduler_if.slave bus
);

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [COORD_W:0]   sum_t;

  typedef struct packed {
    logic   snap;
    coord_t pos;
    coord_t vel;
  } axis_t;

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, COMMIT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  // object table (position and velocity per entry)
  coord_t pos_x_reg [NUM_OBJ];
  coord_t pos_y_reg [NUM_OBJ];
  coord_t vel_x_reg [NUM_OBJ];
  coord_t vel_y_reg [NUM_OBJ];

  // frame parameters frozen at tick acceptance
  logic   mode_reg;
  coord_t x_min_reg, x_max_reg, y_min_reg, y_max_reg;

  // working copy of the current object; sums carry one extra bit so they never wrap
  sum_t   sum_x_reg, sum_y_reg;
  coord_t wvel_x_reg, wvel_y_reg;

  // checked results waiting for COMMIT
  axis_t  res_x_reg, res_y_reg;
  axis_t  res_x_next, res_y_next;

  logic   done_reg, overrun_reg, cfg_drop_reg;
  logic   busy_w, accept_w, cfg_ok_w, last_obj_w;

  assign busy_w     = (state_reg != IDLE);
  assign accept_w   = (state_reg == IDLE) && bus.frame_tick;
  assign cfg_ok_w   = (state_reg == IDLE) && bus.cfg_we;
  assign last_obj_w = (idx_reg == IDX_W'(NUM_OBJ - 1));

  // Range check and snap for one axis. Any sum outside [lo, hi] snaps. With
  // lo > hi every sum is outside, and the (s <= lo) test picks the bound.
  function automatic axis_t axis_step(input sum_t s, input coord_t lo,
                                      input coord_t hi, input coord_t v,
                                      input logic clamp);
    axis_t  r;
    sum_t   lo_e;
    sum_t   hi_e;
    coord_t v_min;
    coord_t v_max;
    lo_e  = sum_t'(lo);
    hi_e  = sum_t'(hi);
    v_min = {1'b1, {(COORD_W-1){1'b0}}};
    v_max = {1'b0, {(COORD_W-1){1'b1}}};
    r     = '0;
    if ((s >= lo_e) && (s <= hi_e)) begin
      r.snap = 1'b0;
      r.pos  = s[COORD_W-1:0];
      r.vel  = v;
    end else begin
      r.snap = 1'b1;
      r.pos  = (s <= lo_e) ? lo : hi;
      if (clamp)
        r.vel = '0;
      else if (v == v_min)
        r.vel = v_max;
      else
        r.vel = -v;
    end
    return r;
  endfunction

  // next-state and object-index sequencing
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (bus.frame_tick) begin
          state_next = FETCH;
          idx_next   = '0;
        end
      end
      FETCH:  state_next = CHECK;
      CHECK:  state_next = COMMIT;
      COMMIT: begin
        if (last_obj_w) begin
          state_next = DONE;
        end else begin
          state_next = FETCH;
          idx_next   = idx_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // state and index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // shadow the mode and rectangle when a tick is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg  <= 1'b0;
      x_min_reg <= '0;
      x_max_reg <= '0;
      y_min_reg <= '0;
      y_max_reg <= '0;
    end else if (accept_w) begin
      mode_reg  <= bus.mode;
      x_min_reg <= bus.x_min;
      x_max_reg <= bus.x_max;
      y_min_reg <= bus.y_min;
      y_max_reg <= bus.y_max;
    end
  end

  // FETCH: load the current entry and form the widened sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x_reg  <= '0;
      sum_y_reg  <= '0;
      wvel_x_reg <= '0;
      wvel_y_reg <= '0;
    end else if (state_reg == FETCH) begin
      sum_x_reg  <= sum_t'(pos_x_reg[idx_reg]) + sum_t'(vel_x_reg[idx_reg]);
      sum_y_reg  <= sum_t'(pos_y_reg[idx_reg]) + sum_t'(vel_y_reg[idx_reg]);
      wvel_x_reg <= vel_x_reg[idx_reg];
      wvel_y_reg <= vel_y_reg[idx_reg];
    end
  end

  // CHECK: range test both axes against the shadow rectangle
  always_comb begin
    res_x_next = axis_step(sum_x_reg, x_min_reg, x_max_reg, wvel_x_reg, mode_reg);
    res_y_next = axis_step(sum_y_reg, y_min_reg, y_max_reg, wvel_y_reg, mode_reg);
  end

  // hold the checked results for COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_x_reg <= '0;
      res_y_reg <= '0;
    end else if (state_reg == CHECK) begin
      res_x_reg <= res_x_next;
      res_y_reg <= res_y_next;
    end
  end

  // The table updates from COMMIT during a pass and from cfg_we only while idle.
  // The two sources are mutually exclusive by state.
  generate
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_entry
      // one table entry: reset clear, commit write-back or config write
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pos_x_reg[gi] <= '0;
          pos_y_reg[gi] <= '0;
          vel_x_reg[gi] <= '0;
          vel_y_reg[gi] <= '0;
        end else if ((state_reg == COMMIT) && (idx_reg == IDX_W'(gi))) begin
          pos_x_reg[gi] <= res_x_reg.pos;
          pos_y_reg[gi] <= res_y_reg.pos;
          vel_x_reg[gi] <= res_x_reg.vel;
          vel_y_reg[gi] <= res_y_reg.vel;
        end else if (cfg_ok_w && (bus.cfg_idx == IDX_W'(gi))) begin
          pos_x_reg[gi] <= bus.cfg_x;
          pos_y_reg[gi] <= bus.cfg_y;
          vel_x_reg[gi] <= bus.cfg_vx;
          vel_y_reg[gi] <= bus.cfg_vy;
        end
      end
    end
  endgenerate

  // status pulses: done follows DONE, dropped ticks and writes flag while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      cfg_drop_reg <= 1'b0;
    end else begin
      done_reg     <= (state_reg == DONE);
      overrun_reg  <= busy_w && bus.frame_tick;
      cfg_drop_reg <= busy_w && bus.cfg_we;
    end
  end

  assign bus.rd_x     = pos_x_reg[bus.rd_idx];
  assign bus.rd_y     = pos_y_reg[bus.rd_idx];
  assign bus.busy     = busy_w;
  assign bus.done     = done_reg;
  assign bus.hit      = (state_reg == COMMIT) && (res_x_reg.snap || res_y_reg.snap);
  assign bus.overrun  = overrun_reg;
  assign bus.cfg_drop = cfg_drop_reg;

endmodule

// File: tb/tb_motion_bound_scheduler.sv
// Randomized bench for motion_bound_scheduler with a plain-integer
// reference model of the object table and the per-frame motion rules.
module tb_motion_bound_scheduler;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // reference model state
  int mx [N];
  int my [N];
  int mvx[N];
  int mvy[N];
  bit s_mode;
  int s_xl, s_xh, s_yl, s_yh;

  motion_bound_scheduler_if #(.IDX_W(3), .COORD_W(16)) bus ();

  motion_bound_scheduler #(.NUM_OBJ(N), .IDX_W(3), .COORD_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  // One axis of one frame: move, and if the result leaves [lo, hi], put it on the nearer bound.
  task automatic model_axis(input int p, input int v, input int lo, input int hi, input bit clamp,
                            output int np, output int nv, output bit snap);
    int s;
    s = p + v;
    if (s >= lo && s <= hi) begin
      np = s; nv = v; snap = 1'b0;
    end else begin
      snap = 1'b1;
      np   = (s <= lo) ? lo : hi;
      if (clamp)          nv = 0;
      else if (v == -32768) nv = 32767;
      else                 nv = -v;
    end
  endtask

  // Apply one full frame to the model; return which cycles should show hit.
  task automatic model_frame(output logic [31:0] hit_mask);
    bit sx, sy;
    hit_mask = '0;
    for (int k = 0; k < N; k++) begin
      model_axis(mx[k], mvx[k], s_xl, s_xh, s_mode, mx[k], mvx[k], sx);
      model_axis(my[k], mvy[k], s_yl, s_yh, s_mode, my[k], mvy[k], sy);
      if (sx || sy) hit_mask[3*k+2] = 1'b1;
    end
  endtask

  task automatic set_frame(input bit m, input int xl, input int xh, input int yl, input int yh);
    s_mode = m; s_xl = xl; s_xh = xh; s_yl = yl; s_yh = yh;
    bus.mode  = m;
    bus.x_min = 16'(xl); bus.x_max = 16'(xh);
    bus.y_min = 16'(yl); bus.y_max = 16'(yh);
  endtask

  task automatic write_obj(input int i, input int x, input int y, input int vx, input int vy);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'(i);
    bus.cfg_x = 16'(x); bus.cfg_y = 16'(y); bus.cfg_vx = 16'(vx); bus.cfg_vy = 16'(vy);
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
    mx[i] = x; my[i] = y; mvx[i] = vx; mvy[i] = vy;
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 3'(i);
      #1;
      check_eq($sformatf("%s_obj%0d_pos", tag, i), {bus.rd_x, bus.rd_y},
               {16'(mx[i]), 16'(my[i])});
    end
  endtask

  // Run one frame and check every status output cycle by cycle, then the table.
  task automatic run_pass(input string tag, input bit inj_tick, input bit inj_cfg, input bit wr_tick);
    logic [31:0] hit_m, done_m, busy_m, ovr_m, drop_m, exp_hit;
    int wi, wx, wy, wvx, wvy;
    hit_m = '0; done_m = '0; busy_m = '0; ovr_m = '0; drop_m = '0;
    wi = rnd(0, N-1); wx = rnd(-100, 100); wy = rnd(-100, 100);
    wvx = rnd(-20, 20); wvy = rnd(-20, 20);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    if (wr_tick) begin
      bus.cfg_we = 1'b1; bus.cfg_idx = 3'(wi);
      bus.cfg_x = 16'(wx); bus.cfg_y = 16'(wy); bus.cfg_vx = 16'(wvx); bus.cfg_vy = 16'(wvy);
      mx[wi] = wx; my[wi] = wy; mvx[wi] = wvx; mvy[wi] = wvy;
    end
    model_frame(exp_hit);
    for (int c = 0; c < 28; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin bus.frame_tick = 1'b0; bus.cfg_we = 1'b0; end
      hit_m[c]  = bus.hit;
      done_m[c] = bus.done;
      busy_m[c] = bus.busy;
      ovr_m[c]  = bus.overrun;
      drop_m[c] = bus.cfg_drop;
      // scramble the live frame inputs; only the shadow copies may matter
      if (c == 3) begin
        bus.mode = ~bus.mode;
        bus.x_min = 16'($urandom); bus.x_max = 16'($urandom);
        bus.y_min = 16'($urandom); bus.y_max = 16'($urandom);
      end
      if (c == 5 && inj_tick) bus.frame_tick = 1'b1;
      if (c == 6) bus.frame_tick = 1'b0;
      if (c == 8 && inj_cfg) begin
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'($urandom);
        bus.cfg_x = 16'($urandom); bus.cfg_y = 16'($urandom);
        bus.cfg_vx = 16'($urandom); bus.cfg_vy = 16'($urandom);
      end
      if (c == 9) bus.cfg_we = 1'b0;
    end
    check_eq({tag, "_busy"}, busy_m, 32'h01FF_FFFF);
    check_eq({tag, "_done"}, done_m, 32'h1 << 25);
    check_eq({tag, "_hit"}, hit_m, exp_hit);
    check_eq({tag, "_overrun"}, ovr_m, inj_tick ? (32'h1 << 6) : 32'h0);
    check_eq({tag, "_cfg_drop"}, drop_m, inj_cfg ? (32'h1 << 9) : 32'h0);
    set_frame(s_mode, s_xl, s_xh, s_yl, s_yh);
    check_table(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_flags"}, {bus.busy, bus.done, bus.hit, bus.overrun, bus.cfg_drop}, 5'b0);
  endtask

  initial begin
    logic [31:0] done_m;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.frame_tick = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = '0;
    bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_vx = '0; bus.cfg_vy = '0; bus.rd_idx = '0;
    set_frame(1'b0, 0, 100, 0, 100);
    for (int i = 0; i < N; i++) begin mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_table("reset");
    @(negedge clk) rst_n = 1'b1;

    // in-range move, bounce at max, bounce at min
    write_obj(0, 10, 20, 3, -4);
    write_obj(1, 98, 50, 5, 0);
    write_obj(2, 50, 1, 0, -3);
    for (int i = 3; i < N; i++) write_obj(i, rnd(10, 90), rnd(10, 90), rnd(-5, 5), rnd(-5, 5));
    set_frame(1'b0, 0, 100, 0, 100);
    run_pass("bounce", 1'b0, 1'b0, 1'b0);
    run_pass("bounce2", 1'b0, 1'b0, 1'b0);

    // clamp mode at min
    write_obj(2, 50, 1, 0, -3);
    set_frame(1'b1, 0, 100, 0, 100);
    run_pass("clamp", 1'b0, 1'b0, 1'b0);
    run_pass("clamp2", 1'b0, 1'b0, 1'b0);

    // sums beyond the coordinate range, and saturating negation
    write_obj(0, 32767, 0, 1, 0);
    write_obj(1, 0, 0, -32768, 0);
    set_frame(1'b0, 0, 32767, -10, 10);
    run_pass("ovf", 1'b0, 1'b0, 1'b0);
    run_pass("ovf2", 1'b0, 1'b0, 1'b0);

    // contention: dropped tick and write, then write together with tick
    run_pass("contend", 1'b1, 1'b1, 1'b0);
    run_pass("wr_tick", 1'b0, 1'b0, 1'b1);

    // reset during CHECK of object 3
    @(negedge clk) bus.frame_tick = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) bus.frame_tick = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; end
    check_idle_outputs("midrst");
    check_table("midrst");
    @(negedge clk) rst_n = 1'b1;
    done_m = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      done_m[c] = bus.done | bus.busy;
    end
    check_eq("midrst_no_done", done_m, 32'h0);
    for (int i = 0; i < N; i++) write_obj(i, rnd(-50, 50), rnd(-50, 50), rnd(-30, 30), rnd(-30, 30));
    set_frame(1'b0, -40, 40, -40, 40);
    run_pass("after_rst", 1'b0, 1'b0, 1'b0);

    // randomized frames, including inverted and full-range rectangles
    for (int r = 0; r < 8; r++) begin
      int a, b, c2, d;
      if (r % 3 == 2) begin
        for (int i = 0; i < N; i++)
          write_obj(i, rnd(-32768, 32767), rnd(-32768, 32767), rnd(-32768, 32767), rnd(-32768, 32767));
        a = rnd(-32768, 32767); b = rnd(-32768, 32767);
        c2 = rnd(-32768, 32767); d = rnd(-32768, 32767);
      end else begin
        a = rnd(-200, 0); b = rnd(0, 200); c2 = rnd(-200, 0); d = rnd(0, 200);
        if (r == 4) begin a = 30; b = -30; end
      end
      set_frame(1'($urandom), a, b, c2, d);
      run_pass($sformatf("rand%0d", r), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_bound_scheduler.md
Name: motion_bound_scheduler

Overview:
- Per-frame sequencer that advances NUM_OBJ on-screen objects by their velocity and keeps each one inside a configured rectangle.
- On each frame_tick it walks the object table serially:
  - adds velocity to position on each axis;
  - range-checks each axis (in range when min <= value <= max);
  - if out of range, snaps the value to the nearest bound and bounces or stops it.
- Sits between the frame timing generator and the renderer. The renderer reads positions through a combinational read port.

Parameters:
- NUM_OBJ, 8, number of objects in the table (2..64).
- IDX_W, 3, object index width; must equal ceil(log2(NUM_OBJ)).
- COORD_W, 16, signed two's-complement width of positions, velocities and bounds.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  single-cycle pulse that requests one update pass.
- mode  in  1  0 = bounce, 1 = clamp; sampled on tick acceptance.
- x_min, x_max, y_min, y_max  in  COORD_W each  rectangle bounds, signed; sampled on tick acceptance.
- cfg_we  in  1  writes one object entry.
- cfg_idx  in  IDX_W  index of the entry to write.
- cfg_x, cfg_y, cfg_vx, cfg_vy  in  COORD_W each  write data.
- rd_idx  in  IDX_W  renderer read index.
- rd_x, rd_y  out  COORD_W each  combinational read of the committed position.
- busy  out  1  high while a pass is running.
- done  out  1  one-cycle pulse when a pass completes.
- hit  out  1  one-cycle pulse in COMMIT if either axis of the current object was snapped.
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy.
- cfg_drop  out  1  one-cycle pulse when cfg_we arrives while busy.

Behaviour:
- Reset (async, rst_n=0):
  - all table entries are 0;
  - FSM goes to IDLE and the object index is 0;
  - busy, done, hit, overrun and cfg_drop are 0;
  - rd_x and rd_y therefore read 0.
- Reset asserted mid-pass aborts the pass immediately. No partial done is produced.
- FSM states: IDLE -> FETCH -> CHECK -> COMMIT -> (FETCH with idx+1 | DONE) -> IDLE.
- IDLE:
  - cfg_we writes all four fields of entry cfg_idx on the clock edge.
  - frame_tick=1 latches mode and the four bounds into shadow registers, clears idx and goes to FETCH. If cfg_we and frame_tick are both high, the write lands first and the pass sees it.
- FETCH: loads entry idx into working registers and computes the sums sx = x+vx and sy = y+vy in COORD_W+1 bits. Sums never wrap.
- CHECK, per axis, with s = the sum and lo/hi = the shadow bounds:
  - in range when lo <= s <= hi: keep s, velocity unchanged.
  - otherwise snap = (s <= lo) ? lo : hi.
  - Bounce mode: velocity is negated. Negating -2^(COORD_W-1) saturates to 2^(COORD_W-1)-1.
  - Clamp mode: velocity becomes 0.
  - If lo > hi, the axis is always out of range and the snap rule above applies as written.
- COMMIT:
  - writes the new position and velocity to entry idx;
  - pulses hit if either axis snapped;
  - goes to DONE if idx == NUM_OBJ-1, otherwise increments idx and returns to FETCH.
- DONE: done=1 for one cycle, then IDLE. busy is high in FETCH, CHECK, COMMIT and DONE.
- Latency: a tick sampled at edge 0 gives done high in the cycle after edge 3*NUM_OBJ+1 (25 cycles for NUM_OBJ=8). The next tick is accepted on the edge where the FSM is IDLE.
- Ticks and config writes while busy:
  - frame_tick while busy is dropped and overrun pulses the next cycle;
  - cfg_we while busy is dropped, the table is unchanged and cfg_drop pulses.
- Bound inputs and mode may change during a pass without effect; only the shadow copies are used.
- rd_x/rd_y show the last committed values. An entry changes only at its own COMMIT edge.

Test Plan:
- Reset mid-pass: assert rst_n=0 during CHECK of object 3 -> all outputs and table are 0 immediately; no done; next tick runs a normal pass.
- In-range move: obj0 at (10,20) with v=(3,-4), bounds x and y both 0..100, tick -> rd(0)=(13,16), v unchanged, hit=0, done exactly 25 cycles after the tick.
- Bounce at max: obj1 at x=98 with vx=5, xmax=100, bounce mode -> x=100, vx=-5, hit=1 during object 1's COMMIT.
- Bounce at min and clamp mode:
  - bounce: obj2 at y=1 with vy=-3, ymin=0 -> y=0, vy=3;
  - same stimulus in clamp mode -> y=0, vy=0.
- Overflow and saturation, COORD_W=16:
  - x=32767, vx=1, xmax=32767 -> x=32767, no wrap, vx=-1;
  - vx=-32768 with bounce -> vx=32767.
- Contention: tick while busy -> overrun pulse, pass unaffected; cfg_we while busy -> cfg_drop pulse, entry unchanged; cfg_we together with tick in IDLE -> the pass uses the newly written entry.
